// File: rtl/multi_frame_readout_seq.sv
// Multi-frame SPAD readout sequencer: integrates a programmable number of shutter windows,
// then walks every pixel address, waits for the data to settle and streams {addr, mask, din} words.
module multi_frame_readout_seq #(
  parameter int N_PIX  = 512,
  parameter int ADDR_W = 10,
  parameter int DIN_W  = 5,
  parameter int WAIT_W = 4,
  parameter int CNT_W  = 32,
  parameter logic [ADDR_W+DIN_W:0] HEADER = '1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     shutter_tick,
  input  logic [CNT_W-1:0]         shutter_periods,
  input  logic [WAIT_W-1:0]        data_wait_cycles,
  input  logic [N_PIX-1:0]         pix_mask,
  input  logic                     mask_skip,
  input  logic                     header_en,
  input  logic [15:0]              num_frames,
  input  logic [DIN_W-1:0]         din,
  output logic [ADDR_W-1:0]        pix_addr,
  output logic                     mem_clear,
  output logic                     read_en,
  output logic                     spad_on_en,
  output logic                     pix_off,
  output logic [ADDR_W+DIN_W:0]    dout,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic                     frame_done,
  output logic [15:0]              frame_cnt,
  output logic                     busy
);

  localparam int DOUT_W = ADDR_W + 1 + DIN_W;
  localparam int MASK_W = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_PIX - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RECORD,
    S_HEADER,
    S_SETTLE,
    S_EMIT,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    period_q, period_d;
  logic [WAIT_W-1:0]   settle_q, settle_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DOUT_W-1:0]   dout_q, dout_d;
  logic [15:0]         frame_cnt_q, frame_cnt_d;
  logic [15:0]         frame_inc;
  logic [MASK_W-1:0]   mask_ext;
  logic                cur_masked;

  // Pad the mask to the full address space so indexing by pix_addr is always in range.
  for (genvar gi = 0; gi < MASK_W; gi++) begin : g_mask
    if (gi < N_PIX) begin : g_in
      assign mask_ext[gi] = pix_mask[gi];
    end else begin : g_pad
      assign mask_ext[gi] = 1'b0;
    end
  end

  assign cur_masked = mask_ext[addr_q];
  assign frame_inc  = (frame_cnt_q == 16'hFFFF) ? frame_cnt_q : frame_cnt_q + 16'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      period_q    <= '0;
      settle_q    <= '0;
      addr_q      <= '0;
      dout_q      <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      period_q    <= period_d;
      settle_q    <= settle_d;
      addr_q      <= addr_d;
      dout_q      <= dout_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    period_d    = period_q;
    settle_d    = settle_q;
    addr_d      = addr_q;
    dout_d      = dout_q;
    frame_cnt_d = frame_cnt_q;
    read_en     = rst_n;
    mem_clear   = 1'b0;
    spad_on_en  = 1'b0;
    pix_off     = 1'b0;
    dout_valid  = 1'b0;
    dout        = dout_q;
    frame_done  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (en) begin
          frame_cnt_d = '0;
          state_d     = S_CLEAR;
        end
      end
      S_CLEAR: begin
        mem_clear = 1'b1;
        period_d  = '0;
        addr_d    = '0;
        settle_d  = '0;
        state_d   = S_RECORD;
      end
      S_RECORD: begin
        spad_on_en = 1'b1;
        if (period_q >= shutter_periods) begin
          state_d = header_en ? S_HEADER : S_SETTLE;
        end else if (shutter_tick) begin
          period_d = period_q + CNT_W'(1);
        end
      end
      S_HEADER: begin
        dout_valid = 1'b1;
        dout       = HEADER;
        if (dout_ready) begin
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        pix_off = cur_masked;
        // A skipped pixel costs exactly one cycle and never reaches the output.
        if (mask_skip && cur_masked) begin
          settle_d = '0;
          if (addr_q == LAST_ADDR) begin
            state_d = S_DONE;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end else if (settle_q == data_wait_cycles) begin
          settle_d = '0;
          dout_d   = {addr_q, cur_masked, din};
          state_d  = S_EMIT;
        end else begin
          settle_d = settle_q + WAIT_W'(1);
        end
      end
      S_EMIT: begin
        dout_valid = 1'b1;
        if (dout_ready) begin
          if (addr_q == LAST_ADDR) begin
            state_d = S_DONE;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = S_SETTLE;
          end
        end
      end
      S_DONE: begin
        frame_done  = 1'b1;
        frame_cnt_d = frame_inc;
        if (!en || ((num_frames != 16'd0) && (frame_inc == num_frames))) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_CLEAR;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign pix_addr  = addr_q;
  assign frame_cnt = frame_cnt_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_multi_frame_readout_seq.sv
// Scoreboard bench for multi_frame_readout_seq with a 4-pixel array: expected words are queued
// when a run is launched and popped on every dout handshake.
module tb_multi_frame_readout_seq;

  localparam int ADDR_W = 10;
  localparam int DIN_W  = 5;
  localparam int WAIT_W = 4;
  localparam int CNT_W  = 32;
  localparam logic [15:0] HDR = 16'hFFFF;

  logic              clk;
  logic              rst_n;
  logic              en;
  logic              shutter_tick;
  logic [CNT_W-1:0]  shutter_periods;
  logic [WAIT_W-1:0] data_wait_cycles;
  logic [3:0]        pix_mask;
  logic              mask_skip;
  logic              header_en;
  logic [15:0]       num_frames;
  logic [DIN_W-1:0]  din;
  logic [ADDR_W-1:0] pix_addr;
  logic              mem_clear, read_en, spad_on_en, pix_off;
  logic [15:0]       dout;
  logic              dout_valid;
  logic              dout_ready;
  logic              frame_done;
  logic [15:0]       frame_cnt;
  logic              busy;

  multi_frame_readout_seq #(
    .N_PIX(4), .ADDR_W(ADDR_W), .DIN_W(DIN_W), .WAIT_W(WAIT_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .shutter_tick(shutter_tick),
    .shutter_periods(shutter_periods), .data_wait_cycles(data_wait_cycles),
    .pix_mask(pix_mask), .mask_skip(mask_skip), .header_en(header_en),
    .num_frames(num_frames), .din(din), .pix_addr(pix_addr), .mem_clear(mem_clear),
    .read_en(read_en), .spad_on_en(spad_on_en), .pix_off(pix_off), .dout(dout),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .frame_done(frame_done),
    .frame_cnt(frame_cnt), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [15:0] sb[$];
  int seed = 3;
  int done_total = 0, clr_total = 0, spad_total = 0, poff2_total = 0;
  int base_done, base_clr, base_spad, base_poff2;
  int cyc = 0;
  bit restart = 1'b0;
  int tcnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] good(input logic [ADDR_W-1:0] a);
    return 5'(int'(a) * 7 + seed);
  endfunction

  function automatic logic [15:0] exp_word(input int a);
    logic [ADDR_W-1:0] aa;
    logic [1:0] ai;
    aa = ADDR_W'(a);
    ai = 2'(a);
    return {aa, pix_mask[ai], good(aa)};
  endfunction

  always begin
    @(posedge clk);
    #1;
    shutter_tick = (tcnt % 3 == 0);
    tcnt++;
  end

  // din is only valid on the cycle the settle window should close, so early or late capture shows up as bad data.
  always @(negedge clk) begin
    logic [15:0] w;
    if (restart) cyc = 0;
    else if (cyc < 1000) cyc++;
    din = (cyc == int'(data_wait_cycles)) ? good(pix_addr) : ~good(pix_addr);
    restart = (dout_valid && dout_ready) || spad_on_en || (pix_off && mask_skip);
    if (frame_done) done_total++;
    if (mem_clear) clr_total++;
    if (spad_on_en) spad_total++;
    if (pix_off) begin
      check("pixoff_only_masked", {31'd0, pix_mask[pix_addr[1:0]]}, 1);
      if (pix_addr == 10'd2) poff2_total++;
    end
    if (dout_valid && dout_ready) begin
      check("word_expected", {31'd0, sb.size() != 0}, 1);
      if (sb.size() != 0) begin
        w = sb.pop_front();
        check("dout_word", {16'd0, dout}, {16'd0, w});
        $display("word addr=%0d dout=%04h exp=%04h", pix_addr, dout, w);
      end
    end
  end

  task automatic start_run(input int n, input logic [15:0] nf);
    for (int f = 0; f < n; f++) begin
      if (header_en) sb.push_back(HDR);
      for (int a = 0; a < 4; a++) begin
        if (!(mask_skip && pix_mask[2'(a)])) sb.push_back(exp_word(a));
      end
    end
    base_done  = done_total;
    base_clr   = clr_total;
    base_spad  = spad_total;
    base_poff2 = poff2_total;
    num_frames = nf;
    en = 1'b1;
  endtask

  task automatic finish_run(input int n, input string tag);
    int t;
    t = 0;
    while ((done_total - base_done) < n && t < 4000) begin
      @(posedge clk); #1; t++;
    end
    check({tag, "_timeout"}, {31'd0, t < 4000}, 1);
    en = 1'b0;
    t = 0;
    while (busy && t < 4000) begin
      @(posedge clk); #1; t++;
    end
    repeat (3) begin @(posedge clk); #1; end
    check({tag, "_frame_done_pulses"}, 32'(done_total - base_done), 32'(n));
    check({tag, "_mem_clear_pulses"}, 32'(clr_total - base_clr), 32'(n));
    check({tag, "_sb_drained"}, 32'(sb.size()), 0);
    check({tag, "_frame_cnt"}, {16'd0, frame_cnt}, 32'(n));
    check({tag, "_idle"}, {31'd0, busy}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    logic [15:0] held_dout;
    logic [ADDR_W-1:0] held_addr;
    rst_n = 1'b0; en = 1'b0; shutter_periods = 2; data_wait_cycles = 0;
    pix_mask = 4'b0000; mask_skip = 1'b0; header_en = 1'b0; num_frames = 1;
    dout_ready = 1'b1; shutter_tick = 1'b0; din = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dout", {16'd0, dout}, 0);
    check("rst_valid", {31'd0, dout_valid}, 0);
    check("rst_read_en", {31'd0, read_en}, 0);
    check("rst_frame_cnt", {16'd0, frame_cnt}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    rst_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check("idle_read_en", {31'd0, read_en}, 1);
    check("idle_busy", {31'd0, busy}, 0);

    // basic single frame
    seed = 5;
    start_run(1, 1);
    finish_run(1, "basic");

    // masked pixel emitted with flag
    seed = 11; pix_mask = 4'b0100; mask_skip = 1'b0;
    start_run(1, 1);
    finish_run(1, "mask_flag");
    check("mask_flag_pixoff_addr2", {31'd0, (poff2_total - base_poff2) > 0}, 1);

    // masked pixel skipped
    seed = 17; mask_skip = 1'b1;
    start_run(1, 1);
    finish_run(1, "mask_skip");
    pix_mask = 4'b0000; mask_skip = 1'b0;

    // three frames with header, zero shutter periods
    seed = 23; header_en = 1'b1; shutter_periods = 0;
    start_run(3, 3);
    finish_run(3, "three_frames");
    check("three_frames_record_cycles", 32'(spad_total - base_spad), 3);

    // long settle window
    seed = 29; data_wait_cycles = 15; shutter_periods = 2;
    start_run(1, 1);
    finish_run(1, "settle15");
    data_wait_cycles = 0; header_en = 1'b0;

    // ready stall at address 1, en dropped mid-frame in continuous mode
    seed = 31;
    start_run(1, 0);
    t = 0;
    while (pix_addr != 10'd1 && t < 2000) begin @(posedge clk); #1; t++; end
    dout_ready = 1'b0; en = 1'b0;
    t = 0;
    while (!dout_valid && t < 100) begin @(posedge clk); #1; t++; end
    check("stall_reach_emit", {31'd0, dout_valid}, 1);
    held_dout = dout; held_addr = pix_addr;
    check("stall_addr_is_1", {22'd0, held_addr}, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_dout_stable", {16'd0, dout}, {16'd0, held_dout});
      check("stall_addr_stable", {22'd0, pix_addr}, {22'd0, held_addr});
    end
    @(posedge clk); #1;
    dout_ready = 1'b1;
    finish_run(1, "stall");

    // reset while holding EMIT at address 2
    seed = 37;
    start_run(1, 1);
    t = 0;
    while (pix_addr != 10'd2 && t < 2000) begin @(posedge clk); #1; t++; end
    dout_ready = 1'b0;
    t = 0;
    while (!dout_valid && t < 100) begin @(posedge clk); #1; t++; end
    check("rst_mid_emit_addr", {22'd0, pix_addr}, 2);
    rst_n = 1'b0;
    #1;
    check("rst_mid_dout", {16'd0, dout}, 0);
    check("rst_mid_valid", {31'd0, dout_valid}, 0);
    check("rst_mid_addr", {22'd0, pix_addr}, 0);
    check("rst_mid_read_en", {31'd0, read_en}, 0);
    check("rst_mid_busy", {31'd0, busy}, 0);
    sb.delete();
    en = 1'b0; dout_ready = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    check("post_rst_idle", {31'd0, busy}, 0);
    seed = 41;
    start_run(1, 1);
    finish_run(1, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_frame_readout_seq.md
MULTI_FRAME_READOUT_SEQ -- requirements
Module: multi_frame_readout_seq

Interface
REQ-001 SHALL take parameter N_PIX, default 512: pixels per frame, addresses 0..N_PIX-1.
REQ-002 SHALL take parameter ADDR_W, default 10: pixel address width, with 2^ADDR_W >= N_PIX.
REQ-003 SHALL take parameter DIN_W, default 5: pixel data width.
REQ-004 SHALL take parameter WAIT_W, default 4: settle-counter width.
REQ-005 SHALL take parameter CNT_W, default 32: shutter-period counter width.
REQ-006 SHALL take parameter HEADER, default all-ones: frame header word.
REQ-007 SHALL define DOUT_W = ADDR_W+1+DIN_W.
REQ-008 SHALL have the following ports (name, direction, width, meaning):
- clk  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  run enable.
- shutter_tick  in  1  one-cycle pulse per laser window, synchronous to clk.
- shutter_periods  in  CNT_W  windows to integrate per frame.
- data_wait_cycles  in  WAIT_W  settle cycles before sampling din.
- pix_mask  in  N_PIX  hot-pixel mask, 1 = masked.
- mask_skip  in  1  1 = masked pixels are not emitted.
- header_en  in  1  1 = emit HEADER before each frame's pixel words.
- num_frames  in  16  frames per run; 0 = continuous.
- din  in  DIN_W  pixel data from the IC.
- pix_addr  out  ADDR_W  current pixel address to the IC.
- mem_clear, read_en, spad_on_en, pix_off  out  1  IC controls.
- dout  out  DOUT_W  pixel word {addr, mask flag, din}.
- dout_valid  out  1  word available.
- dout_ready  in  1  FIFO can accept.
- frame_done  out  1  one-cycle pulse at frame end.
- frame_cnt  out  16  frames completed in the current run.
- busy  out  1  state != IDLE.

Function
REQ-009 SHALL implement states IDLE, CLEAR, RECORD, HEADER, SETTLE, EMIT, DONE.
REQ-010 IDLE: read_en=1, all other controls 0; on en=1 SHALL clear frame_cnt and go to CLEAR.
REQ-011 CLEAR: SHALL assert mem_clear for exactly one cycle, clear the period counter and pix_addr, then go to RECORD.
REQ-012 RECORD: SHALL assert spad_on_en and increment the period counter on each shutter_tick.
REQ-013 RECORD SHALL exit when the period counter >= shutter_periods: to HEADER if header_en=1, otherwise to SETTLE. With shutter_periods=0, RECORD lasts exactly one cycle.
REQ-014 HEADER: SHALL present dout=HEADER with dout_valid=1 and go to SETTLE on the dout_ready handshake.
REQ-015 SETTLE: SHALL drive pix_off=pix_mask[pix_addr] and count settle cycles from 0.
REQ-016 SETTLE: when the count == data_wait_cycles, SHALL register dout={pix_addr, pix_mask[pix_addr], din} and go to EMIT. Total SETTLE time is data_wait_cycles+1 cycles.
REQ-017 SETTLE: if mask_skip=1 and the pixel is masked, SHALL spend one cycle and then advance the address (or go to DONE) without producing a word.
REQ-018 EMIT: dout_valid=1; dout and pix_addr SHALL be held stable until dout_ready=1.
REQ-019 EMIT: on handshake, SHALL go to DONE if pix_addr=N_PIX-1, otherwise increment pix_addr and return to SETTLE. Back-to-back handshakes are allowed.
REQ-020 DONE: SHALL pulse frame_done and increment frame_cnt (saturating at 16'hFFFF).
REQ-021 DONE SHALL go to IDLE if en=0 or the new frame_cnt == num_frames (num_frames != 0); otherwise to CLEAR.
REQ-022 Deasserting en mid-frame SHALL NOT truncate the frame; the current frame completes.
REQ-023 dout_valid SHALL be 0 in every state except HEADER and EMIT.
REQ-024 read_en SHALL be 1 in all states.
REQ-025 Parameter changes SHALL require only N_PIX <= 2^ADDR_W; no other code changes.

Reset
REQ-026 rst_n=0 SHALL immediately force state IDLE and clear all counters, pix_addr, dout, dout_valid, frame_done, frame_cnt, mem_clear, spad_on_en and pix_off to 0; read_en=0.
REQ-027 Reset SHALL take effect mid-frame without emitting a partial handshake; after release, the block idles until en=1.

Verification
REQ-028 N_PIX=4, wait=0, periods=2, header_en=0, ready=1, one frame -> words 0x000+din for addresses 0..3, one frame_done pulse, return to IDLE.
REQ-029 mask=4'b0100, mask_skip=0 -> address 2 is emitted with flag=1 and pix_off=1 during its SETTLE; with mask_skip=1 -> only 3 words are emitted.
REQ-030 dout_ready low for 5 cycles during EMIT -> dout and pix_addr stay stable; no word lost or duplicated.
REQ-031 num_frames=3, en held high -> exactly 3 frame_done pulses and 3 mem_clear pulses, with each frame preceded by HEADER when header_en=1.
REQ-032 data_wait_cycles=15 -> SETTLE lasts 16 cycles per pixel; din changes before the final cycle are not captured.
REQ-033 rst_n pulsed low during EMIT at address 2 -> outputs are zero immediately; after release with en=1, readout restarts at address 0.
